// File: rtl/mul_fac8_seq.sv
// Frame sequencer for the mul_fac8_1 twiddle-multiply stage: counts 16-lane beats,
// steers the multiplier enable/select, and re-aligns valid/SOP/EOP behind its latency.
module mul_fac8_seq #(
    parameter int unsigned BEATS_PER_FRAME = 32,
    parameter int unsigned SEL_HOLD        = 8,
    parameter int unsigned MUL_LAT         = 1,
    parameter int unsigned CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       din_valid,
    output logic       mul_en,
    output logic [1:0] mul_select,
    output logic       dout_valid,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       frame_done,
    output logic       busy,
    output logic       drop_err
);

    localparam int unsigned SEL_LSB = $clog2(SEL_HOLD);
    localparam int unsigned DRN_W   = 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [MUL_LAT-1:0] sop_q, sop_d;
    logic [MUL_LAT-1:0] eop_q, eop_d;
    logic               first_c;
    logic               last_c;

    // Next-state, beat counting and the multiplier-side controls.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = '0;
        frame_done_d = 1'b0;
        mul_en       = 1'b0;
        mul_select   = 2'd0;
        drop_err     = 1'b0;
        first_c      = 1'b0;
        last_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                drop_err = din_valid;
                // The cycle showing frame_done is already IDLE but must not re-arm.
                if (start && !frame_done_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mul_en     = din_valid;
                mul_select = beat_cnt_q[SEL_LSB+1:SEL_LSB];
                if (din_valid) begin
                    first_c = (beat_cnt_q == '0);
                    last_c  = (beat_cnt_q == LAST_BEAT);
                    if (last_c) begin
                        beat_cnt_d = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                drop_err    = din_valid;
                drain_cnt_d = drain_cnt_q + DRN_W'(1);
                if (drain_cnt_q == LAST_DRN) begin
                    drain_cnt_d  = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shift toward the MSB; the top stage lines up with the multiplier output.
        vld_d = MUL_LAT'({vld_q, mul_en});
        sop_d = MUL_LAT'({sop_q, first_c});
        eop_d = MUL_LAT'({eop_q, last_c});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            vld_q        <= '0;
            sop_q        <= '0;
            eop_q        <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            frame_done_q <= frame_done_d;
            vld_q        <= vld_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
        end
    end

    assign dout_valid = vld_q[MUL_LAT-1];
    assign dout_sop   = sop_q[MUL_LAT-1];
    assign dout_eop   = eop_q[MUL_LAT-1];
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_fac8_seq.sv
// Scoreboard bench for mul_fac8_seq: MUL_LAT=1 and MUL_LAT=3 builds share one stimulus
// stream; a frame/beat-level model predicts outputs that a separate monitor compares.
module tb_mul_fac8_seq;

    localparam int BPF = 32;
    localparam int SH  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic din_valid = 1'b0;

    logic       en1, dv1, sop1, eop1, fd1, busy1, drop1;
    logic [1:0] sel1;
    logic       en3, dv3, sop3, eop3, fd3, busy3, drop3;
    logic [1:0] sel3;

    mul_fac8_seq #(.BEATS_PER_FRAME(32), .SEL_HOLD(8), .MUL_LAT(1), .CNT_W(5)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .din_valid(din_valid),
        .mul_en(en1), .mul_select(sel1), .dout_valid(dv1), .dout_sop(sop1),
        .dout_eop(eop1), .frame_done(fd1), .busy(busy1), .drop_err(drop1)
    );

    mul_fac8_seq #(.BEATS_PER_FRAME(32), .SEL_HOLD(8), .MUL_LAT(3), .CNT_W(5)) u_l3 (
        .clk(clk), .rst(rst), .start(start), .din_valid(din_valid),
        .mul_en(en3), .mul_select(sel3), .dout_valid(dv3), .dout_sop(sop3),
        .dout_eop(eop3), .frame_done(fd3), .busy(busy3), .drop_err(drop3)
    );

    typedef struct {
        int cyc;
        bit sop;
        bit eop;
    } exp_t;

    typedef struct {
        bit       skip;
        bit [1:0] en;
        bit [1:0] drop;
        bit [1:0] busy;
        bit [1:0] sel0;
        bit [1:0] sel1;
    } rec_t;

    exp_t qo1[$];
    exp_t qo3[$];
    int   qd1[$];
    int   qd3[$];
    rec_t qc[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model state, one slot per latency build.
    bit m_run    [2];
    int m_beats  [2];
    int m_done   [2];
    int m_arm_ok [2];
    int lat      [2] = '{1, 3};

    bit stim_done = 1'b0;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic step(input bit st, input bit dv, input bit r);
        rec_t     rec;
        exp_t     e;
        bit [1:0] s;
        @(negedge clk);
        start     = st;
        din_valid = dv;
        rst       = r;
        rec.skip  = r;
        rec.sel0  = 2'd0;
        rec.sel1  = 2'd0;
        for (int i = 0; i < 2; i++) begin
            rec.en[i]   = m_run[i] & dv;
            rec.drop[i] = !m_run[i] & dv;
            rec.busy[i] = m_run[i] || (cyc < m_done[i]);
            s = m_run[i] ? 2'((m_beats[i] / SH) % 4) : 2'd0;
            if (i == 0) rec.sel0 = s;
            else        rec.sel1 = s;
            if (r) begin
                m_run[i]    = 1'b0;
                m_beats[i]  = 0;
                m_done[i]   = 0;
                m_arm_ok[i] = cyc + 1;
                if (i == 0) begin
                    while (qo1.size() > 0 && qo1[$].cyc > cyc) void'(qo1.pop_back());
                    while (qd1.size() > 0 && qd1[$] > cyc) void'(qd1.pop_back());
                end else begin
                    while (qo3.size() > 0 && qo3[$].cyc > cyc) void'(qo3.pop_back());
                    while (qd3.size() > 0 && qd3[$] > cyc) void'(qd3.pop_back());
                end
            end else if (m_run[i] && dv) begin
                e.cyc = cyc + lat[i];
                e.sop = (m_beats[i] == 0);
                e.eop = (m_beats[i] == BPF - 1);
                if (i == 0) qo1.push_back(e);
                else        qo3.push_back(e);
                m_beats[i]++;
                if (m_beats[i] == BPF) begin
                    m_run[i]    = 1'b0;
                    m_done[i]   = cyc + lat[i] + 1;
                    m_arm_ok[i] = m_done[i] + 1;
                    if (i == 0) qd1.push_back(m_done[i]);
                    else        qd3.push_back(m_done[i]);
                end
            end else if (!m_run[i] && st && cyc >= m_arm_ok[i]) begin
                m_run[i]   = 1'b1;
                m_beats[i] = 0;
            end
        end
        qc.push_back(rec);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic beats(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        idle(2);
        // contiguous frame
        step(1'b1, 1'b0, 1'b0);
        beats(32);
        idle(8);
        // gapped frame: three idle cycles after beat 8
        step(1'b1, 1'b0, 1'b0);
        beats(8);
        idle(3);
        beats(24);
        idle(8);
        // stray beat in IDLE, then a normal frame
        step(1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        beats(32);
        idle(8);
        // reset landing on beat 20, then a fresh frame
        step(1'b1, 1'b0, 1'b0);
        beats(20);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        beats(32);
        idle(8);
        // start and din_valid held high across two frames
        for (int k = 0; k < 90; k++) step(1'b1, 1'b1, 1'b0);
        idle(8);
        // randomized soak
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 180) == 0);
        end
        idle(12);
        stim_done = 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    rec_t mrec;
    exp_t me;
    int   md;

    // Monitor: pops per-cycle expectations and the dout/done scoreboards.
    always @(negedge clk) begin
        #2;
        if (qc.size() > 0) begin
            mrec = qc.pop_front();
            if (!mrec.skip) begin
                chk("l1_mul_en",     int'(en1),   int'(mrec.en[0]));
                chk("l1_mul_select", int'(sel1),  int'(mrec.sel0));
                chk("l1_drop_err",   int'(drop1), int'(mrec.drop[0]));
                chk("l1_busy",       int'(busy1), int'(mrec.busy[0]));
                chk("l3_mul_en",     int'(en3),   int'(mrec.en[1]));
                chk("l3_mul_select", int'(sel3),  int'(mrec.sel1));
                chk("l3_drop_err",   int'(drop3), int'(mrec.drop[1]));
                chk("l3_busy",       int'(busy3), int'(mrec.busy[1]));
            end
        end

        if (dv1) begin
            if (qo1.size() == 0) begin
                chk("l1_dout_unexpected", 1, 0);
            end else begin
                me = qo1.pop_front();
                chk("l1_dout_cycle", cyc, me.cyc);
                chk("l1_dout_sop", int'(sop1), int'(me.sop));
                chk("l1_dout_eop", int'(eop1), int'(me.eop));
            end
        end else begin
            chk("l1_sop_eop_without_valid", int'({sop1, eop1}), 0);
        end
        if (fd1) begin
            if (qd1.size() == 0) begin
                chk("l1_done_unexpected", 1, 0);
            end else begin
                md = qd1.pop_front();
                chk("l1_done_cycle", cyc, md);
            end
        end

        if (dv3) begin
            if (qo3.size() == 0) begin
                chk("l3_dout_unexpected", 1, 0);
            end else begin
                me = qo3.pop_front();
                chk("l3_dout_cycle", cyc, me.cyc);
                chk("l3_dout_sop", int'(sop3), int'(me.sop));
                chk("l3_dout_eop", int'(eop3), int'(me.eop));
            end
        end else begin
            chk("l3_sop_eop_without_valid", int'({sop3, eop3}), 0);
        end
        if (fd3) begin
            if (qd3.size() == 0) begin
                chk("l3_done_unexpected", 1, 0);
            end else begin
                md = qd3.pop_front();
                chk("l3_done_cycle", cyc, md);
            end
        end

        if (stim_done && qc.size() == 0) begin
            chk("l1_pending_dout", qo1.size(), 0);
            chk("l1_pending_done", qd1.size(), 0);
            chk("l3_pending_dout", qo3.size(), 0);
            chk("l3_pending_done", qd3.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
